// File: rtl/gray_pointer_monitor.sv
// Receiving end of an async FIFO gray-pointer link: synchronizes the remote pointer and
// registers full/empty, almost and level. Define GRAY_POINTER_CHECK_EN to add a sticky gray_error.
module gray_pointer_monitor #(
    parameter int address_size     = 4,
    parameter int sync_stages      = 2,
    parameter int is_write_side    = 0,
    parameter int almost_threshold = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [address_size:0] gray_pointer_remote,
    input  logic [address_size:0] gray_pointer_local_next,
    output logic                  status_flag,
    output logic                  almost_flag,
    output logic [address_size:0] level,
    output logic [address_size:0] gray_pointer_synced
`ifdef GRAY_POINTER_CHECK_EN
    ,
    output logic                  gray_error
`endif
);

    localparam int pw         = address_size + 1;
    localparam int fifo_depth = 2 ** address_size;

    typedef logic [pw-1:0] ptr_t;

    // Top two pointer bits inverted; for address_size=1 this covers the whole pointer.
    localparam ptr_t full_mask    = pw'(3) << (pw - 2);
    localparam bit   reset_status = (is_write_side == 0);
    localparam bit   reset_almost = (is_write_side != 0) ? (almost_threshold >= fifo_depth) : 1'b1;

    function automatic ptr_t gray_to_bin(input ptr_t g);
        ptr_t b;
        b[pw-1] = g[pw-1];
        for (int i = pw - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    ptr_t sync_q [sync_stages];

    // NOTE: these are individual synchronizer flops, not a RAM, so every stage is reset to
    // give the comparison a defined remote pointer straight out of reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < sync_stages; i++) begin
                sync_q[i] <= '0;
            end
        end else begin
            sync_q[0] <= gray_pointer_remote;
            for (int i = 1; i < sync_stages; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
        end
    end

    assign gray_pointer_synced = sync_q[sync_stages-1];

    ptr_t local_bin;
    ptr_t remote_bin;
    ptr_t level_d;
    logic status_d;
    logic almost_d;

    // NOTE: every combinational output gets a default first so no path can infer a latch.
    always_comb begin
        local_bin  = gray_to_bin(gray_pointer_local_next);
        remote_bin = gray_to_bin(gray_pointer_synced);
        level_d    = '0;
        status_d   = 1'b0;
        almost_d   = 1'b0;
        if (is_write_side != 0) begin
            status_d = (gray_pointer_local_next == (gray_pointer_synced ^ full_mask));
            level_d  = local_bin - remote_bin;
            almost_d = (int'(level_d) >= fifo_depth - almost_threshold);
        end else begin
            status_d = (gray_pointer_local_next == gray_pointer_synced);
            level_d  = remote_bin - local_bin;
            almost_d = (int'(level_d) <= almost_threshold);
        end
    end

    // Registered on the same edge as the local counter, so local moves show with no extra lag.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            status_flag <= reset_status;
            almost_flag <= reset_almost;
            level       <= '0;
        end else begin
            status_flag <= status_d;
            almost_flag <= almost_d;
            level       <= level_d;
        end
    end

`ifdef GRAY_POINTER_CHECK_EN
    ptr_t synced_prev;
    ptr_t synced_diff;

    assign synced_diff = synced_prev ^ gray_pointer_synced;

    // A clear-lowest-bit test flags any step that changes more than one gray bit.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            synced_prev <= '0;
            gray_error  <= 1'b0;
        end else begin
            synced_prev <= gray_pointer_synced;
            if (((synced_diff & (synced_diff - ptr_t'(1))) != '0) || (int'(level) > fifo_depth)) begin
                gray_error <= 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_gray_pointer_monitor.sv
// Self-checking bench for gray_pointer_monitor: one empty-side and one full-side instance,
// expected outputs queued on a scoreboard as stimulus is applied and popped when sampled.
module tb_gray_pointer_monitor;

    localparam int walk_len = 240;

    typedef struct {
        string      name;
        bit         side;   // 0 = empty-side instance, 1 = full-side instance
        logic [6:0] value;  // {status, almost, level}
    } exp_t;

    logic       clk;
    logic       reset;
    logic [4:0] e_remote, e_local, f_remote, f_local;
    logic       e_status, e_almost, f_status, f_almost;
    logic [4:0] e_level, f_level, e_synced, f_synced;
`ifdef GRAY_POINTER_CHECK_EN
    logic       e_gray_error, f_gray_error;
`endif

    exp_t sb[$];
    exp_t e;
    logic [6:0] got;
    int vectors = 0;
    int miscompares = 0;

    gray_pointer_monitor #(.address_size(4), .sync_stages(2), .is_write_side(0), .almost_threshold(2)) u_empty (
        .clk                     (clk),
        .reset                   (reset),
        .gray_pointer_remote     (e_remote),
        .gray_pointer_local_next (e_local),
        .status_flag             (e_status),
        .almost_flag             (e_almost),
        .level                   (e_level),
        .gray_pointer_synced     (e_synced)
`ifdef GRAY_POINTER_CHECK_EN
        ,
        .gray_error              (e_gray_error)
`endif
    );

    gray_pointer_monitor #(.address_size(4), .sync_stages(2), .is_write_side(1), .almost_threshold(2)) u_full (
        .clk                     (clk),
        .reset                   (reset),
        .gray_pointer_remote     (f_remote),
        .gray_pointer_local_next (f_local),
        .status_flag             (f_status),
        .almost_flag             (f_almost),
        .level                   (f_level),
        .gray_pointer_synced     (f_synced)
`ifdef GRAY_POINTER_CHECK_EN
        ,
        .gray_error              (f_gray_error)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    function automatic logic [4:0] to_gray(input logic [4:0] b);
        return b ^ (b >> 1);
    endfunction

    function automatic logic [6:0] obs(input bit side);
        return side ? {f_status, f_almost, f_level} : {e_status, e_almost, e_level};
    endfunction

    // Outputs are sampled and inputs driven 1 ns after the active edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        e_remote = '0; e_local = '0; f_remote = '0; f_local = '0;
        sb.push_back('{"reset_empty", 1'b0, {1'b1, 1'b1, 5'd0}});
        sb.push_back('{"reset_full", 1'b1, {1'b0, 1'b0, 5'd0}});
        repeat (3) tick();
        repeat (2) begin
            e = sb.pop_front(); got = obs(e.side); vectors++;
            if (got !== e.value) begin miscompares++; $display("FAIL %s: got s=%b a=%b l=%0d want s=%b a=%b l=%0d", e.name, got[6], got[5], got[4:0], e.value[6], e.value[5], e.value[4:0]); end
        end
        vectors++;
        if (e_synced !== 5'd0) begin miscompares++; $display("FAIL reset_synced: got %b want 00000", e_synced); end
        reset = 1'b1;
        tick();
    endtask

    task automatic test_remote_write();
        e_remote = 5'b00001;
        sb.push_back('{"rw_edge1_still_empty", 1'b0, {1'b1, 1'b1, 5'd0}});
        sb.push_back('{"rw_edge2", 1'b0, {1'b0, 1'b1, 5'd1}});
        tick(); tick();
        e = sb.pop_front(); got = obs(e.side); vectors++;
        if (got !== e.value) begin miscompares++; $display("FAIL %s: got s=%b a=%b l=%0d want s=%b a=%b l=%0d", e.name, got[6], got[5], got[4:0], e.value[6], e.value[5], e.value[4:0]); end
        tick();
        e = sb.pop_front(); got = obs(e.side); vectors++;
        if (got !== e.value) begin miscompares++; $display("FAIL %s: got s=%b a=%b l=%0d want s=%b a=%b l=%0d", e.name, got[6], got[5], got[4:0], e.value[6], e.value[5], e.value[4:0]); end
    endtask

    task automatic test_full_detect();
        f_local = 5'b11000;
        sb.push_back('{"full_detect", 1'b1, {1'b1, 1'b1, 5'd16}});
        tick();
        e = sb.pop_front(); got = obs(e.side); vectors++;
        if (got !== e.value) begin miscompares++; $display("FAIL %s: got s=%b a=%b l=%0d want s=%b a=%b l=%0d", e.name, got[6], got[5], got[4:0], e.value[6], e.value[5], e.value[4:0]); end
    endtask

    task automatic test_wrap();
        f_remote = 5'b11000;
        f_local  = 5'b10000;
        sb.push_back('{"wrap_31_vs_16", 1'b1, {1'b0, 1'b1, 5'd15}});
        repeat (3) tick();
        e = sb.pop_front(); got = obs(e.side); vectors++;
        if (got !== e.value) begin miscompares++; $display("FAIL %s: got s=%b a=%b l=%0d want s=%b a=%b l=%0d", e.name, got[6], got[5], got[4:0], e.value[6], e.value[5], e.value[4:0]); end
        f_local = 5'b00000;
        sb.push_back('{"wrap_0_vs_16_full", 1'b1, {1'b1, 1'b1, 5'd16}});
        tick();
        e = sb.pop_front(); got = obs(e.side); vectors++;
        if (got !== e.value) begin miscompares++; $display("FAIL %s: got s=%b a=%b l=%0d want s=%b a=%b l=%0d", e.name, got[6], got[5], got[4:0], e.value[6], e.value[5], e.value[4:0]); end
        f_remote = 5'b11001;
        sb.push_back('{"wrap_release_edge1_still_full", 1'b1, {1'b1, 1'b1, 5'd16}});
        sb.push_back('{"wrap_release_edge2", 1'b1, {1'b0, 1'b1, 5'd15}});
        tick(); tick();
        e = sb.pop_front(); got = obs(e.side); vectors++;
        if (got !== e.value) begin miscompares++; $display("FAIL %s: got s=%b a=%b l=%0d want s=%b a=%b l=%0d", e.name, got[6], got[5], got[4:0], e.value[6], e.value[5], e.value[4:0]); end
        tick();
        e = sb.pop_front(); got = obs(e.side); vectors++;
        if (got !== e.value) begin miscompares++; $display("FAIL %s: got s=%b a=%b l=%0d want s=%b a=%b l=%0d", e.name, got[6], got[5], got[4:0], e.value[6], e.value[5], e.value[4:0]); end
    endtask

    task automatic test_async_reset();
        for (int i = 2; i <= 7; i++) begin
            e_remote = to_gray(5'(i));
            tick();
        end
        sb.push_back('{"pre_reset_level7", 1'b0, {1'b0, 1'b0, 5'd7}});
        repeat (3) tick();
        e = sb.pop_front(); got = obs(e.side); vectors++;
        if (got !== e.value) begin miscompares++; $display("FAIL %s: got s=%b a=%b l=%0d want s=%b a=%b l=%0d", e.name, got[6], got[5], got[4:0], e.value[6], e.value[5], e.value[4:0]); end
        #3;
        reset = 1'b0;
        sb.push_back('{"async_reset_empty", 1'b0, {1'b1, 1'b1, 5'd0}});
        sb.push_back('{"async_reset_full", 1'b1, {1'b0, 1'b0, 5'd0}});
        #1;
        repeat (2) begin
            e = sb.pop_front(); got = obs(e.side); vectors++;
            if (got !== e.value) begin miscompares++; $display("FAIL %s: got s=%b a=%b l=%0d want s=%b a=%b l=%0d", e.name, got[6], got[5], got[4:0], e.value[6], e.value[5], e.value[4:0]); end
        end
        vectors++;
        if (e_synced !== 5'd0) begin miscompares++; $display("FAIL async_reset_synced: got %b want 00000", e_synced); end
        #2;
        reset = 1'b1;
        sb.push_back('{"resync_empty_level7", 1'b0, {1'b0, 1'b0, 5'd7}});
        sb.push_back('{"resync_full_level15", 1'b1, {1'b0, 1'b1, 5'd15}});
        repeat (3) tick();
        repeat (2) begin
            e = sb.pop_front(); got = obs(e.side); vectors++;
            if (got !== e.value) begin miscompares++; $display("FAIL %s: got s=%b a=%b l=%0d want s=%b a=%b l=%0d", e.name, got[6], got[5], got[4:0], e.value[6], e.value[5], e.value[4:0]); end
        end
    endtask

    // Both sides of a FIFO modelled as binary write/read pointers; each monitor sees the
    // other side's pointer as it was two cycles earlier.
    task automatic test_random_walk();
        logic [4:0] w, r, w_old, r_old, lvl_e, lvl_f;
        logic [4:0] w_hist [walk_len];
        logic [4:0] r_hist [walk_len];
        reset = 1'b0;
        e_remote = '0; e_local = '0; f_remote = '0; f_local = '0;
        w = '0; r = '0;
        tick();
        reset = 1'b1;
        for (int k = 0; k < walk_len; k++) begin
            w_old = (k >= 2) ? w_hist[k-2] : 5'd0;
            r_old = (k >= 2) ? r_hist[k-2] : 5'd0;
            lvl_f = w - r_old;
            if (((k < walk_len / 2) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0)) && (lvl_f < 5'd16)) w = w + 5'd1;
            if (((k < walk_len / 2) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0)) && (w_old != r)) r = r + 5'd1;
            w_hist[k] = w;
            r_hist[k] = r;
            e_local = to_gray(r); e_remote = to_gray(w);
            f_local = to_gray(w); f_remote = to_gray(r);
            lvl_e = w_old - r;
            lvl_f = w - r_old;
            sb.push_back('{"walk_empty", 1'b0, {(lvl_e == 5'd0), (lvl_e <= 5'd2), lvl_e}});
            sb.push_back('{"walk_full", 1'b1, {(lvl_f == 5'd16), (lvl_f >= 5'd14), lvl_f}});
            tick();
            repeat (2) begin
                e = sb.pop_front(); got = obs(e.side); vectors++;
                if (got !== e.value) begin miscompares++; $display("FAIL %s cycle %0d: got s=%b a=%b l=%0d want s=%b a=%b l=%0d", e.name, k, got[6], got[5], got[4:0], e.value[6], e.value[5], e.value[4:0]); end
            end
        end
`ifdef GRAY_POINTER_CHECK_EN
        vectors++;
        if ({e_gray_error, f_gray_error} !== 2'b00) begin miscompares++; $display("FAIL walk_no_gray_error: got %b%b want 00", e_gray_error, f_gray_error); end
`endif
    endtask

`ifdef GRAY_POINTER_CHECK_EN
    task automatic test_gray_error();
        reset = 1'b0;
        e_remote = '0; e_local = '0;
        tick();
        reset = 1'b1;
        tick();
        e_remote = 5'b00011;
        tick(); tick();
        vectors++;
        if (e_gray_error !== 1'b0) begin miscompares++; $display("FAIL gray_error_early: got %b want 0", e_gray_error); end
        tick();
        vectors++;
        if (e_gray_error !== 1'b1) begin miscompares++; $display("FAIL gray_error_set: got %b want 1", e_gray_error); end
        e_remote = 5'b00010; tick();
        e_remote = 5'b00110; repeat (3) tick();
        vectors++;
        if (e_gray_error !== 1'b1) begin miscompares++; $display("FAIL gray_error_sticky: got %b want 1", e_gray_error); end
        #2;
        reset = 1'b0;
        #1;
        vectors++;
        if (e_gray_error !== 1'b0) begin miscompares++; $display("FAIL gray_error_reset: got %b want 0", e_gray_error); end
        #2;
        reset = 1'b1;
        tick();
    endtask
`endif

    initial begin
        test_reset();
        test_remote_write();
        test_full_detect();
        test_wrap();
        test_async_reset();
        test_random_walk();
`ifdef GRAY_POINTER_CHECK_EN
        test_gray_error();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/gray_pointer_monitor.md
Name: gray_pointer_monitor

Overview:
- Receiving end of the async FIFO gray-pointer interface.
- Takes the gray pointer published by the opposite clock domain's pointer counter and synchronizes it into the local clock domain.
- Compares the synchronized value with the local counter's next gray pointer and produces the registered FIFO status for that domain.
- One instance per side: the write side gives full, the read side gives empty.

Parameters:
- address_size, 4: memory address width. Pointers are address_size+1 bits. fifo_depth = 2**address_size. Legal range is 1 or more.
- sync_stages, 2: number of flops in the remote-pointer synchronizer. Legal range is 2 or more.
- is_write_side, 0: 1 selects full/almost-full logic; 0 selects empty/almost-empty logic.
- almost_threshold, 2: margin for the almost flag, in entries.

Ports:
- clk  input  1  local domain clock.
- reset  input  1  asynchronous reset, active-low (asserted at 0).
- gray_pointer_remote  input  address_size+1  registered gray pointer from the opposite domain.
- gray_pointer_local_next  input  address_size+1  gray_pointer_next from the local gray counter.
- status_flag  output  1  full when is_write_side=1; empty when is_write_side=0.
- almost_flag  output  1  almost-full or almost-empty.
- level  output  address_size+1  occupancy as seen from this domain.
- gray_pointer_synced  output  address_size+1  last synchronizer stage.

Behaviour:
- Synchronizer:
  - sync_stages-deep flop chain on gray_pointer_remote; all stages reset to 0.
  - No logic between stages.
  - gray_pointer_synced is the final stage.
- Gray-to-binary:
  - Combinational conversion of both gray_pointer_local_next and gray_pointer_synced.
  - b[MSB] = g[MSB]; b[i] = b[i+1] ^ g[i].
- Empty side (is_write_side=0):
  - empty_d = (gray_pointer_local_next == gray_pointer_synced).
  - level_d = (remote_bin - local_bin) mod 2**(address_size+1).
  - almost_d = (level_d <= almost_threshold).
- Full side (is_write_side=1):
  - full_d = (gray_pointer_local_next == {~synced[MSB:MSB-1], synced[MSB-2:0]}).
  - When address_size=1, the inverted field covers the whole pointer.
  - level_d = (local_bin - remote_bin) mod 2**(address_size+1).
  - almost_d = (level_d >= fifo_depth - almost_threshold).
- Registering:
  - status_flag, almost_flag and level are all registered on clk.
  - They update on the same edge the local counter registers its next pointer, so local moves have zero extra lag.
- Latency:
  - A remote pointer change first affects the outputs sync_stages+1 edges after it appears on gray_pointer_remote.
  - Flags are therefore pessimistic: they deassert late and never assert late.
- Reset values:
  - Empty side: status_flag=1, almost_flag=1, level=0.
  - Full side: status_flag=0, almost_flag=0 (or 1 if almost_threshold >= fifo_depth), level=0.
  - Synchronizer stages are 0.
- Wrap-around:
  - All arithmetic is modulo 2**(address_size+1).
  - The extra pointer MSB distinguishes full from empty when addresses are equal.
- Simultaneous events: when a local advance and a synced remote change land on the same edge, the outputs reflect both new values on that edge. No priority is needed.
- Range: level is never saturated. In legal operation it stays within 0..fifo_depth.
- Reset mid-operation:
  - Asserting reset clears every flop immediately, without waiting for clk.
  - Both domains' counters and monitors must share the reset event.
  - Deassertion is expected to be synchronized externally.

Optional Feature:
- Macro: GRAY_POINTER_CHECK_EN.
- Defined:
  - Adds output port gray_error (1 bit), reset 0.
  - A register holds the previous gray_pointer_synced.
  - gray_error sets and stays sticky until reset when either holds:
    - popcount(previous ^ current) > 1, meaning a multi-bit gray jump;
    - registered level > fifo_depth.
- Not defined:
  - No gray_error port.
  - No extra flops.
  - Functional outputs are identical either way.

Test Plan:
All scenarios use defaults: address_size=4, sync_stages=2.
1. Reset: hold reset=0, toggle clk.
   - Empty side: status_flag=1, almost_flag=1, level=0, gray_pointer_synced=0.
   - Full side: status_flag=0, almost_flag=0, level=0.
2. Remote write on the empty side: local=5'b00000; gray_pointer_remote goes 00000->00001 before edge 0.
   - status_flag falls, level=1, almost_flag stays 1, all after edge 2 (3 edges).
3. Full detection on the full side: remote stable at 00000 long enough to sync; gray_pointer_local_next=11000 (binary 16).
   - status_flag=1, level=16, almost_flag=1, on the same edge.
4. Wrap-around on the full side: local_next goes gray 10000->00000 (binary 31->0); remote synced=11000 (binary 16).
   - status_flag=1, level=16.
   - Then local_next=00001: status_flag=0? No change to remote means local cannot legally advance; instead move remote to 11001 and local stays.
   - After 3 edges: status_flag=0, level=15, almost_flag=1.
5. Async reset mid-operation: empty side at level=7, assert reset=0 between clock edges.
   - Outputs go to status_flag=1, level=0 immediately, with no clk edge.
   - Release reset, then re-sync: level returns to 7 within 3 edges.
6. GRAY_POINTER_CHECK_EN defined: remote jumps 00000->00011.
   - gray_error=1 after 3 edges.
   - Remains 1 through further legal moves until reset=0.
